// File: rtl/mult_div_pkg.sv
// mult_div_pkg: state encoding and latency shared by the sequential multiply/divide units
package mult_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_LATENCY = MULT_WIDTH + 1;
endpackage

// File: rtl/mult_booth_seq_if.sv
// mult_booth_seq_if: start/operands to the multiplier, busy/done/hi/lo back; master = control unit, slave = multiplier
interface mult_booth_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op_a, op_b, input busy, done, hi, lo);
  modport slave (input start, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (p, m in; p_next out): add/sub m on upper(p) by p[1:0], then arithmetic shift right
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] p,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+1:0] p_next
);
  logic [WIDTH:0] upper;
  logic [WIDTH:0] sum;
  always_comb begin
    upper = p[2*WIDTH+1:WIDTH+1];
    sum = (p[1:0] == 2'b01) ? upper + m : (p[1:0] == 2'b10) ? upper - m : upper;
    p_next = {sum[WIDTH], sum, p[WIDTH:1]};
  end
endmodule

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: sequential signed Booth multiplier (clk, reset_n; bus slave: start/op_a/op_b in, busy/done/hi/lo out)
module mult_booth_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset_n,
  mult_booth_seq_if.slave bus
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] m;
  logic [2*WIDTH+1:0] p;
  logic [2*WIDTH+1:0] p_next;
  booth_step #(.WIDTH(WIDTH)) u_step (.p(p), .m(m), .p_next(p_next));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      m <= '0;
      p <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            m <= {bus.op_a[WIDTH-1], bus.op_a};
            p <= {{(WIDTH+1){1'b0}}, bus.op_b, 1'b0};
            cnt <= CNT_W'(WIDTH);
            bus.busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p <= p_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            {bus.hi, bus.lo} <= p_next[2*WIDTH:1];
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
